stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 153 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: three debounced active-low buttons feed a four-state Moore FSM
// that commands the time counter and the display lap freeze.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss_n,
  input  logic       btn_clr_n,
  input  logic       btn_lap_n,
  output logic [1:0] cnt_ctrl,
  output logic       disp_hold,
  output logic       running,
  output logic [1:0] state_dbg
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COUNT = 2'b01,
    S_LAP   = 2'b10,
    S_PAUSE = 2'b11
  } state_t;

  // Bit order everywhere: [0] start/stop, [1] clear, [2] lap.
  logic [2:0] btn_raw;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] press;

  assign btn_raw = {btn_lap_n, btn_clr_n, btn_ss_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_db
    logic          stable_q;
    logic [CW-1:0] cnt_q;
    logic          pulse_q;

    // A new level is accepted only after DB_CYCLES consecutive differing samples;
    // the pulse marks acceptance of a press (1->0) and is one cycle wide.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stable_q <= 1'b1;
        cnt_q    <= '0;
        pulse_q  <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        if (sync2_q[i] == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
          stable_q <= sync2_q[i];
          cnt_q    <= '0;
          pulse_q  <= ~sync2_q[i];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign press[i] = pulse_q;
  end

  logic ss_p;
  logic clr_p;
  logic lap_p;

  assign ss_p  = press[0];
  assign clr_p = press[1];
  assign lap_p = press[2];

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority clr > ss > lap, applied only among pulses valid in the current state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ss_p) state_d = S_COUNT;
      S_COUNT: begin
        if (ss_p)       state_d = S_PAUSE;
        else if (lap_p) state_d = S_LAP;
      end
      S_LAP: begin
        if (ss_p)       state_d = S_PAUSE;
        else if (lap_p) state_d = S_COUNT;
      end
      S_PAUSE: begin
        if (clr_p)      state_d = S_IDLE;
        else if (ss_p)  state_d = S_COUNT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [1:0] cnt_ctrl_d;
  logic       disp_hold_d;
  logic       running_d;

  // Outputs decode the next state and are registered, so they move together with
  // the state register and cnt_ctrl can never pass through an intermediate code.
  always_comb begin
    cnt_ctrl_d  = 2'b00;
    disp_hold_d = 1'b0;
    running_d   = 1'b0;
    case (state_d)
      S_COUNT: begin
        cnt_ctrl_d = 2'b01;
        running_d  = 1'b1;
      end
      S_LAP: begin
        cnt_ctrl_d  = 2'b01;
        disp_hold_d = 1'b1;
        running_d   = 1'b1;
      end
      S_PAUSE: cnt_ctrl_d = 2'b10;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ctrl  <= 2'b00;
      disp_hold <= 1'b0;
      running   <= 1'b0;
    end else begin
      cnt_ctrl  <= cnt_ctrl_d;
      disp_hold <= disp_hold_d;
      running   <= running_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DB_CYCLES=4: button presses push the expected
// {cnt_ctrl, disp_hold, running} into a queue, popped when the outputs settle.
module tb_stopwatch_ctrl;

  localparam int DB = 4;

  localparam logic [3:0] O_IDLE  = 4'b0000;
  localparam logic [3:0] O_COUNT = 4'b0101;
  localparam logic [3:0] O_LAP   = 4'b0111;
  localparam logic [3:0] O_PAUSE = 4'b1000;

  localparam logic [2:0] B_SS  = 3'b001;
  localparam logic [2:0] B_CLR = 3'b010;
  localparam logic [2:0] B_LAP = 3'b100;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       btn_ss_n = 1'b1;
  logic       btn_clr_n = 1'b1;
  logic       btn_lap_n = 1'b1;
  logic [1:0] cnt_ctrl;
  logic       disp_hold;
  logic       running;
  logic [1:0] state_dbg;

  stopwatch_ctrl #(.DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_ss_n  (btn_ss_n),
    .btn_clr_n (btn_clr_n),
    .btn_lap_n (btn_lap_n),
    .cnt_ctrl  (cnt_ctrl),
    .disp_hold (disp_hold),
    .running   (running),
    .state_dbg (state_dbg)
  );

  // scoreboard
  logic [3:0] exp_q[$];
  logic [3:0] cur_exp;
  logic [3:0] pre_obs;
  logic [3:0] hit_obs;
  logic [3:0] got_exp;
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [3:0] obs();
    return {cnt_ctrl, disp_hold, running};
  endfunction

  // driver tasks
  task automatic drive_btns(input logic [2:0] mask);
    btn_ss_n  = ~mask[0];
    btn_clr_n = ~mask[1];
    btn_lap_n = ~mask[2];
  endtask

  // Press buttons right after an edge, hold for 'hold' cycles, then wait out the
  // release debounce. pre_obs is sampled one cycle before the outputs may react
  // (2 sync + DB debounce + 1 register), hit_obs on the cycle they should.
  task automatic press(input logic [2:0] mask, input int hold, input logic [3:0] exp);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    drive_btns(mask);
    for (int c = 1; c <= hold || c <= 3 + DB; c++) begin
      @(posedge clk); #1;
      if (c == 2 + DB) pre_obs = obs();
      if (c == 3 + DB) hit_obs = obs();
      if (c == hold) drive_btns(3'b000);
    end
    repeat (DB + 4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== O_IDLE) begin
      n_fail++;
      $display("FAIL reset_async: got %b expected %b", obs(), O_IDLE);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs() !== O_IDLE) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b", obs(), O_IDLE);
    end
    cur_exp = O_IDLE;
  endtask

  task automatic test_glitch();
    press(B_SS, DB - 1, O_IDLE);
    got_exp = exp_q.pop_front();
    n_checks++;
    if (hit_obs !== got_exp) begin
      n_fail++;
      $display("FAIL glitch_edge: got %b expected %b", hit_obs, got_exp);
    end
    n_checks++;
    if (obs() !== got_exp) begin
      n_fail++;
      $display("FAIL glitch_after: got %b expected %b", obs(), got_exp);
    end
  endtask

  task automatic test_press_latency();
    press(B_SS, 20, O_COUNT);
    got_exp = exp_q.pop_front();
    n_checks++;
    if (pre_obs !== O_IDLE) begin
      n_fail++;
      $display("FAIL latency_early: got %b expected %b", pre_obs, O_IDLE);
    end
    n_checks++;
    if (hit_obs !== got_exp) begin
      n_fail++;
      $display("FAIL latency_edge: got %b expected %b", hit_obs, got_exp);
    end
    n_checks++;
    if (obs() !== got_exp) begin
      n_fail++;
      $display("FAIL held_single_pulse: got %b expected %b", obs(), got_exp);
    end
    cur_exp = got_exp;
  endtask

  // Table-driven sequence of presses, each checked for latency, effect and stability.
  task automatic test_sequence(input string name, input logic [2:0] masks[],
                               input logic [3:0] exps[]);
    for (int i = 0; i < masks.size(); i++) begin
      press(masks[i], $urandom_range(DB, DB + 8), exps[i]);
      got_exp = exp_q.pop_front();
      n_checks++;
      if (pre_obs !== cur_exp) begin
        n_fail++;
        $display("FAIL %s[%0d]_early: got %b expected %b", name, i, pre_obs, cur_exp);
      end
      n_checks++;
      if (hit_obs !== got_exp) begin
        n_fail++;
        $display("FAIL %s[%0d]_edge: got %b expected %b", name, i, hit_obs, got_exp);
      end
      n_checks++;
      if (obs() !== got_exp) begin
        n_fail++;
        $display("FAIL %s[%0d]_after: got %b expected %b", name, i, obs(), got_exp);
      end
      cur_exp = got_exp;
    end
  endtask

  task automatic test_lap();
    test_sequence("lap", '{B_LAP, B_LAP}, '{O_LAP, O_COUNT});
  endtask

  task automatic test_clear_rules();
    test_sequence("clear", '{B_CLR, B_SS, B_CLR}, '{O_COUNT, O_PAUSE, O_IDLE});
  endtask

  task automatic test_simultaneous();
    test_sequence("simul", '{B_SS, B_SS, B_SS | B_CLR},
                  '{O_COUNT, O_PAUSE, O_IDLE});
  endtask

  task automatic test_back_to_back();
    test_sequence("b2b",
      '{B_SS, B_LAP, B_CLR, B_SS, B_LAP, B_SS, B_SS | B_LAP, B_SS, B_LAP,
        B_SS | B_LAP, B_CLR | B_LAP, B_LAP | B_CLR, B_SS | B_CLR},
      '{O_COUNT, O_LAP, O_LAP, O_PAUSE, O_PAUSE, O_COUNT, O_PAUSE, O_COUNT, O_LAP,
        O_PAUSE, O_IDLE, O_IDLE, O_COUNT});
  endtask

  task automatic test_reset_mid_lap();
    test_sequence("to_lap", '{B_LAP}, '{O_LAP});
    @(posedge clk); #1;
    drive_btns(B_SS);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== O_IDLE) begin
      n_fail++;
      $display("FAIL reset_mid_lap: got %b expected %b", obs(), O_IDLE);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(O_COUNT);
    for (int c = 1; c <= 3 + DB; c++) begin
      @(posedge clk); #1;
      if (c == 2 + DB) pre_obs = obs();
      if (c == 3 + DB) hit_obs = obs();
    end
    got_exp = exp_q.pop_front();
    n_checks++;
    if (pre_obs !== O_IDLE) begin
      n_fail++;
      $display("FAIL held_after_reset_early: got %b expected %b", pre_obs, O_IDLE);
    end
    n_checks++;
    if (hit_obs !== got_exp) begin
      n_fail++;
      $display("FAIL held_after_reset_edge: got %b expected %b", hit_obs, got_exp);
    end
    drive_btns(3'b000);
    repeat (DB + 4) @(posedge clk);
    #1;
    cur_exp = got_exp;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press_latency();
    test_lap();
    test_clear_rules();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_lap();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
